instr_fetch_stage: RTL and testbench

Pipelined instruction-fetch stage for the WISC-style 16-bit CPU. It sits directly upstream of `decode` and replaces the single-cycle `fetch` path. It owns the PC and issues requests to a variable-latency instruction memory over a req/done handshake. It presents each fetched instruction to decode through a valid/stall IF/ID output register, honouring branch/jump redirects from execute and stopping at HALT.

---
 rtl/instr_fetch_stage_pkg.sv | 34 +++
 rtl/instr_fetch_stage_skid_buf.sv | 28 ++
 rtl/instr_fetch_stage.sv | 156 +++++++++++++++
 tb/tb_instr_fetch_stage.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage:
// state encodings, opcode field, HALT/NOP constants, IF payload.
package instr_fetch_stage_pkg;

  localparam logic [1:0] S_FETCH     = 2'd0;
  localparam logic [1:0] S_DISCARD   = 2'd1;
  localparam logic [1:0] S_WAIT_SLOT = 2'd2;
  localparam logic [1:0] S_HALTED    = 2'd3;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 11;

  localparam logic [4:0]  OP_HALT       = 5'b00000;
  localparam logic [15:0] NOP_INSTR_DEF = 16'h0800;
  localparam logic [15:0] RESET_PC_DEF  = 16'h0000;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
  } if_id_t;

  function automatic logic [4:0] opcode(
    input logic [15:0] instr
  );
    return instr[OPC_HI:OPC_LO];
  endfunction

  function automatic logic is_halt(
    input logic [15:0] instr
  );
    return opcode(instr) == OP_HALT;
  endfunction

endpackage

// File: rtl/instr_fetch_stage_skid_buf.sv
// One-entry instruction+PC holding register (fetch_skid_buf).
// Ports: clk, rst (sync, active-low), load/unload/clear, in_data, out_valid, out_data.
module fetch_skid_buf
  import instr_fetch_stage_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   unload,
  input  logic   clear,
  input  if_id_t in_data,
  output logic   out_valid,
  output if_id_t out_data
);

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (unload) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_fetch_stage.sv
// Pipelined fetch stage: owns PC, req/done imem handshake, IF/ID register.
// Ports: clk, rst (sync, active-low), imem_*, id_stall, ex_redirect/target,
//        if_valid/instr/pc/pc_plus_two, err. Option: FETCH_ALIGN_CHECK_EN.
module instr_fetch_stage
  import instr_fetch_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_done,
  input  logic [15:0] imem_rdata,
  input  logic        id_stall,
  input  logic        ex_redirect,
  input  logic [15:0] ex_target,
  output logic        if_valid,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc,
  output logic [15:0] if_pc_plus_two,
  output logic        err
);

  logic [1:0]  state_q;
  logic [15:0] pc_q;
  logic [15:0] pc_plus_two;
  logic        slot_free;
  logic        misalign;
  logic [1:0]  redir_state;

  logic        skid_load;
  logic        skid_unload;
  logic        skid_clear;
  logic        skid_valid;
  if_id_t      skid_in;
  if_id_t      skid_q;

  assign imem_req = rst &
    ((state_q == S_FETCH) || (state_q == S_DISCARD));
  assign imem_addr   = pc_q;
  assign pc_plus_two = pc_q + 16'd2;
  assign slot_free   = !if_valid || !id_stall;

`ifdef FETCH_ALIGN_CHECK_EN
  logic err_q;

  assign misalign = ex_target[0];
  assign err      = err_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (ex_redirect && misalign) begin
      err_q <= 1'b1;
    end
  end
`else
  assign misalign = 1'b0;
  assign err      = 1'b0;
`endif

  // A request still in flight without its done this cycle must be
  // drained before the new address may be issued.
  always_comb begin
    redir_state = S_FETCH;
    if (misalign) begin
      redir_state = S_HALTED;
    end else if (imem_req && !imem_done) begin
      redir_state = S_DISCARD;
    end
  end

  assign skid_in.instr = imem_rdata;
  assign skid_in.pc    = pc_q;

  assign skid_load = rst && !ex_redirect &&
    (state_q == S_FETCH) && imem_done && !slot_free;

  assign skid_unload = rst && !ex_redirect &&
    (state_q == S_WAIT_SLOT) && slot_free && skid_valid;

  assign skid_clear = ex_redirect;

  fetch_skid_buf u_skid (
    .clk       (clk),
    .rst       (rst),
    .load      (skid_load),
    .unload    (skid_unload),
    .clear     (skid_clear),
    .in_data   (skid_in),
    .out_valid (skid_valid),
    .out_data  (skid_q)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= S_FETCH;
      pc_q           <= RESET_PC;
      if_valid       <= 1'b0;
      if_instr       <= NOP_INSTR;
      if_pc          <= 16'h0000;
      if_pc_plus_two <= 16'h0002;
    end else if (ex_redirect) begin
      state_q  <= redir_state;
      pc_q     <= ex_target;
      if_valid <= 1'b0;
      if_instr <= NOP_INSTR;
    end else begin
      // Consumed slot empties unless refilled below.
      if (slot_free) begin
        if_valid <= 1'b0;
        if_instr <= NOP_INSTR;
      end
      case (state_q)
        S_FETCH: begin
          if (imem_done) begin
            pc_q <= pc_plus_two;
            if (slot_free) begin
              if_valid       <= 1'b1;
              if_instr       <= imem_rdata;
              if_pc          <= pc_q;
              if_pc_plus_two <= pc_plus_two;
              state_q <= is_halt(imem_rdata) ?
                S_HALTED : S_FETCH;
            end else begin
              state_q <= S_WAIT_SLOT;
            end
          end
        end
        S_WAIT_SLOT: begin
          if (slot_free && skid_valid) begin
            if_valid       <= 1'b1;
            if_instr       <= skid_q.instr;
            if_pc          <= skid_q.pc;
            if_pc_plus_two <= skid_q.pc + 16'd2;
            state_q <= is_halt(skid_q.instr) ?
              S_HALTED : S_FETCH;
          end
        end
        S_DISCARD: begin
          if (imem_done) begin
            state_q <= S_FETCH;
          end
        end
        S_HALTED: begin
        end
        default: begin
          state_q <= S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Scoreboard bench for instr_fetch_stage with a random-latency memory.
// Expected stream: sequential PCs from reset/redirect target until HALT.
module tb_instr_fetch_stage;

  localparam logic [15:0] NOP = 16'h0800;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_done = 1'b0;
  logic [15:0] imem_rdata = 16'h0;
  logic        id_stall = 1'b0;
  logic        ex_redirect = 1'b0;
  logic [15:0] ex_target = 16'h0;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic [15:0] if_pc_plus_two;
  logic        err;

  logic        imem_req2;
  logic [15:0] imem_addr2;
  logic        imem_done2;
  logic [15:0] imem_rdata2;
  logic        zero = 1'b0;
  logic [15:0] zero16 = 16'h0;
  logic        if_valid2;
  logic [15:0] if_instr2;
  logic [15:0] if_pc2;
  logic [15:0] if_pc_plus_two2;
  logic        err2;

  logic [15:0] halt_addr = 16'h0001;
  int          lat_min = 0;
  int          lat_max = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          pops = 0;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] instr;
  } exp_t;
  exp_t exp_q[$];

  function automatic logic [15:0] mem_word(
    input logic [15:0] a,
    input logic [15:0] h
  );
    if (a == h) return 16'h0000;
    return {2'b10, a[3:1], a[11:1]};
  endfunction

  instr_fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_done      (imem_done),
    .imem_rdata     (imem_rdata),
    .id_stall       (id_stall),
    .ex_redirect    (ex_redirect),
    .ex_target      (ex_target),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc_plus_two (if_pc_plus_two),
    .err            (err)
  );

  assign imem_done2  = imem_req2;
  assign imem_rdata2 = mem_word(imem_addr2, halt_addr);

  instr_fetch_stage #(.RESET_PC(16'hFFFE)) dut2 (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req2),
    .imem_addr      (imem_addr2),
    .imem_done      (imem_done2),
    .imem_rdata     (imem_rdata2),
    .id_stall       (zero),
    .ex_redirect    (zero),
    .ex_target      (zero16),
    .if_valid       (if_valid2),
    .if_instr       (if_instr2),
    .if_pc          (if_pc2),
    .if_pc_plus_two (if_pc_plus_two2),
    .err            (err2)
  );

  task automatic check(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic rebuild(input logic [15:0] start);
    logic [15:0] p;
    p = start;
    exp_q.delete();
`ifdef FETCH_ALIGN_CHECK_EN
    if (p[0]) return;
`endif
    for (int i = 0; i < 200; i++) begin
      exp_q.push_back('{p, mem_word(p, halt_addr)});
      if (p == halt_addr) break;
      p = p + 16'd2;
    end
  endtask

  // Memory: latches address at request start, done after a random wait.
  bit          m_busy = 1'b0;
  int          m_cnt = 0;
  logic [15:0] m_addr = 16'h0;
  always @(posedge clk) begin
    #2;
    if (imem_done) m_busy = 1'b0;
    imem_done  = 1'b0;
    imem_rdata = 16'hDEAD;
    if (!imem_req) begin
      m_busy = 1'b0;
    end else begin
      if (!m_busy) begin
        m_busy = 1'b1;
        m_addr = imem_addr;
        m_cnt  = $urandom_range(lat_max, lat_min);
      end else if (m_cnt > 0) begin
        m_cnt--;
      end
      if (m_cnt == 0) begin
        imem_done  = 1'b1;
        imem_rdata = mem_word(m_addr, halt_addr);
      end
    end
  end

  // Monitor: pops the expected stream on every accepted instruction.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      rebuild(16'h0000);
    end else begin
      if (if_valid && !id_stall) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_extra: got pc %0h expected none",
                   if_pc);
        end else begin
          e = exp_q.pop_front();
          check("sb_pc", {16'h0, if_pc}, {16'h0, e.pc});
          check("sb_instr", {16'h0, if_instr}, {16'h0, e.instr});
          check("sb_pc2", {16'h0, if_pc_plus_two},
                {16'h0, e.pc + 16'd2});
          pops++;
        end
      end
      if (ex_redirect) rebuild(ex_target);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name);
    bit got;
    got = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (if_valid) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got no if_valid expected valid", name);
    end
  endtask

  task automatic restart();
    cyc();
    rst = 1'b0;
    repeat (2) cyc();
    rst = 1'b1;
  endtask

  task automatic redirect(input logic [15:0] t);
    cyc();
    ex_redirect = 1'b1;
    ex_target   = t;
    cyc();
    ex_redirect = 1'b0;
  endtask

  initial begin
    bit found;
    int p0;

    // Reset state
    repeat (3) cyc();
    @(negedge clk);
    check("rst_valid", {31'h0, if_valid}, 0);
    check("rst_instr", {16'h0, if_instr}, {16'h0, NOP});
    check("rst_pc", {16'h0, if_pc}, 0);
    check("rst_pc2", {16'h0, if_pc_plus_two}, 2);
    check("rst_err", {31'h0, err}, 0);
    check("rst_req", {31'h0, imem_req}, 0);

    // Zero-wait, no stall: one instruction per cycle
    cyc();
    rst = 1'b1;
    @(negedge clk);
    check("first_lat_valid", {31'h0, if_valid}, 0);
    check("first_req", {31'h0, imem_req}, 1);
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      check("stream_valid", {31'h0, if_valid}, 1);
      check("stream_pc", {16'h0, if_pc}, 2 * k);
      if (k == 0) begin
        check("wrap_pc", {16'h0, if_pc2}, 32'hFFFE);
        check("wrap_pc2", {16'h0, if_pc_plus_two2}, 0);
      end
      if (k == 1) check("wrap_next", {16'h0, if_pc2}, 0);
    end

    // 3-cycle memory with decode stalled: hold + skid, no request
    cyc();
    id_stall = 1'b1;
    lat_min  = 2;
    lat_max  = 2;
    rst      = 1'b0;
    repeat (2) cyc();
    rst = 1'b1;
    wait_valid("stall_first");
    check("stall_pc0", {16'h0, if_pc}, 0);
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      check("stall_hold", {15'h0, if_valid, if_pc}, 32'h10000);
      if (k >= 4) check("stall_noreq", {31'h0, imem_req}, 0);
    end
    cyc();
    id_stall = 1'b0;
    @(negedge clk);
    check("release_pc0", {15'h0, if_valid, if_pc}, 32'h10000);
    @(negedge clk);
    check("release_pc2", {15'h0, if_valid, if_pc}, 32'h10002);

    // Redirect while the request to 6 is outstanding
    found = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (imem_req && imem_addr == 16'h0006) begin
        found = 1'b1;
        break;
      end
    end
    check("req6_seen", {31'h0, found}, 1);
    redirect(16'h0040);
    wait_valid("redir_valid");
    check("redir_pc", {16'h0, if_pc}, 32'h40);

    // HALT at PC 4, then resume by redirect
    lat_min   = 0;
    lat_max   = 0;
    halt_addr = 16'h0004;
    restart();
    found = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (if_valid && if_instr == 16'h0000) begin
        found = 1'b1;
        break;
      end
    end
    check("halt_seen", {31'h0, found}, 1);
    check("halt_pc", {16'h0, if_pc}, 4);
    repeat (5) begin
      @(negedge clk);
      check("halt_noreq", {31'h0, imem_req}, 0);
    end
    check("halt_drained", {31'h0, if_valid}, 0);
    redirect(16'h0010);
    wait_valid("resume_valid");
    check("resume_pc", {16'h0, if_pc}, 32'h10);

    // Odd redirect target
`ifdef FETCH_ALIGN_CHECK_EN
    redirect(16'h0011);
    @(negedge clk);
    check("align_err", {31'h0, err}, 1);
    check("align_valid", {31'h0, if_valid}, 0);
    repeat (3) begin
      @(negedge clk);
      check("align_noreq", {31'h0, imem_req}, 0);
    end
    cyc();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    @(negedge clk);
    check("align_err_clr", {31'h0, err}, 0);
    wait_valid("align_restart");
    check("align_restart_pc", {16'h0, if_pc}, 0);
`else
    redirect(16'h0011);
    @(negedge clk);
    check("err_tied", {31'h0, err}, 0);
    wait_valid("odd_valid");
    check("odd_pc", {16'h0, if_pc}, 32'h11);
    @(negedge clk);
    check("odd_next", {16'h0, if_pc}, 32'h13);
`endif

    // Random latency, stalls and redirects
    halt_addr = 16'h0030;
    lat_min   = 0;
    lat_max   = 3;
    restart();
    p0 = pops;
    repeat (1500) begin
      cyc();
      id_stall    = ($urandom_range(99) < 30);
      ex_redirect = ($urandom_range(99) < 4);
      ex_target   = 16'($urandom_range(63)) << 1;
    end
    cyc();
    ex_redirect = 1'b0;
    id_stall    = 1'b0;
    check("rand_progress", {31'h0, (pops - p0) > 50}, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
